// File: rtl/output_deskew_register_pkg.sv
// Shared sizing defaults, FSM encoding and lane slicing helper for the
// output deskew register and its row FIFO.
package output_deskew_register_pkg;

  localparam int DEF_DATASIZE   = 16;
  localparam int DEF_ARRAYWIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Low bit position of a lane inside a packed row.
  function automatic int lane_lo(input int lane, input int dsize);
    return lane * dsize;
  endfunction

endpackage

// File: rtl/deskew_row_fifo.sv
// W-entry synchronous row FIFO; head entry is read straight from the array
// so the consumer sees it the cycle after the push.
module deskew_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_reg[k] <= '0;
      end
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/output_deskew_register.sv
// Realigns staggered systolic drain lanes into whole rows and queues them
// for a valid/ready writeback consumer.
module output_deskew_register
  import output_deskew_register_pkg::*;
#(
  parameter int DATASIZE   = DEF_DATASIZE,
  parameter int ARRAYWIDTH = DEF_ARRAYWIDTH,
  parameter int ROWW       = (ARRAYWIDTH > 1) ? $clog2(ARRAYWIDTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           drain_start,
  input  logic                           in_valid,
  input  logic [ARRAYWIDTH*DATASIZE-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ARRAYWIDTH*DATASIZE-1:0] out_data,
  output logic [ROWW-1:0]                out_row,
  output logic                           out_last,
  output logic                           busy,
  output logic                           overflow,
  output logic                           protocol_err
);

  localparam int W  = ARRAYWIDTH;
  localparam int SW = $clog2(2 * W);
  localparam int EW = W * DATASIZE + ROWW + 1;

  state_t                  state_reg;
  logic [SW-1:0]           slot_reg;
  logic                    overflow_reg;
  logic                    protocol_err_reg;
  logic                    adv;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [W*DATASIZE-1:0]   aligned_row;
  logic [ROWW-1:0]         row_idx;
  logic                    row_last;
  logic [EW-1:0]           head_entry;

  assign adv      = in_valid && (state_reg != ST_IDLE);
  assign push     = adv && (state_reg == ST_EMIT);
  assign pop      = out_valid && out_ready;
  assign row_idx  = ROWW'(slot_reg - SW'(W - 1));
  assign row_last = (row_idx == ROWW'(W - 1));

  // Lane gi arrived W-1-gi slots ahead of the row-completing sample.
  for (genvar gi = 0; gi < W; gi++) begin : g_lane
    localparam int D  = W - 1 - gi;
    localparam int LO = lane_lo(gi, DATASIZE);
    if (D == 0) begin : g_direct
      assign aligned_row[LO +: DATASIZE] = in_data[LO +: DATASIZE];
    end else begin : g_delay
      logic [DATASIZE-1:0] dl_reg [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) begin
            dl_reg[k] <= '0;
          end
        end else if (adv) begin
          dl_reg[0] <= in_data[LO +: DATASIZE];
          for (int k = 1; k < D; k++) begin
            dl_reg[k] <= dl_reg[k-1];
          end
        end
      end
      assign aligned_row[LO +: DATASIZE] = dl_reg[D-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      slot_reg         <= '0;
      overflow_reg     <= 1'b0;
      protocol_err_reg <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (drain_start) begin
            slot_reg  <= '0;
            state_reg <= (W == 1) ? ST_EMIT : ST_FILL;
          end
        end
        ST_FILL: begin
          if (drain_start) begin
            protocol_err_reg <= 1'b1;
          end
          if (in_valid) begin
            slot_reg <= slot_reg + 1'b1;
            if (slot_reg == SW'(W - 2)) begin
              state_reg <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (drain_start) begin
            protocol_err_reg <= 1'b1;
          end
          if (in_valid) begin
            if (slot_reg == SW'(2 * W - 2)) begin
              slot_reg  <= '0;
              state_reg <= ST_IDLE;
            end else begin
              slot_reg <= slot_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          slot_reg  <= '0;
        end
      endcase
    end
  end

  deskew_row_fifo #(
    .WIDTH (EW),
    .DEPTH (W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({aligned_row, row_idx, row_last}),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {out_data, out_row, out_last} = head_entry;
  assign out_valid    = !fifo_empty;
  assign busy         = (state_reg != ST_IDLE);
  assign overflow     = overflow_reg;
  assign protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_output_deskew_register.sv
// Directed bench for output_deskew_register with W=4, DATASIZE=16.
module tb_output_deskew_register;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drain_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [1:0]  out_row;
  logic        out_last;
  logic        busy;
  logic        overflow;
  logic        protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  row;
    logic        last;
  } rec_t;

  rec_t mon_q[$];

  output_deskew_register #(
    .DATASIZE   (16),
    .ARRAYWIDTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .drain_start  (drain_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_last     (out_last),
    .busy         (busy),
    .overflow     (overflow),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge view is what the next edge consumes.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_q.push_back('{data: out_data, row: out_row, last: out_last});
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [63:0] stim(input int s);
    logic [63:0] v;
    int r;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      r = s - j;
      if (r < 0 || r > 3) r = 0;
      v[j*16 +: 16] = 16'((r << 8) | j);
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_row(input int r);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) begin
      v[j*16 +: 16] = 16'((r << 8) | j);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drain_start = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_q.delete();
  endtask

  task automatic start_burst();
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
  endtask

  task automatic slot(input int s, input bit ds);
    in_valid = 1'b1;
    in_data = stim(s);
    drain_start = ds;
    tick();
    in_valid = 1'b0;
    drain_start = 1'b0;
  endtask

  task automatic burst(input int gap);
    start_burst();
    for (int s = 0; s < 7; s++) begin
      slot(s, 1'b0);
      repeat (gap) tick();
    end
  endtask

  task automatic check_burst(input string tag);
    check_val({tag, "_nrows"}, 64'(mon_q.size()), 64'd4);
    for (int i = 0; i < mon_q.size() && i < 4; i++) begin
      check_val($sformatf("%s_data%0d", tag, i), mon_q[i].data, exp_row(i));
      check_val($sformatf("%s_row%0d", tag, i), 64'(mon_q[i].row), 64'(i));
      check_val($sformatf("%s_last%0d", tag, i), 64'(mon_q[i].last), 64'(i == 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_overflow", 64'(overflow), 64'd0);
    check_val("rst_protocol_err", 64'(protocol_err), 64'd0);
    check_val("rst_out_data", out_data, 64'd0);

    // Basic drain with ready always high
    out_ready = 1'b1;
    start_burst();
    for (int s = 0; s < 7; s++) begin
      slot(s, 1'b0);
      if (s == 3) check_val("basic_busy_mid", 64'(busy), 64'd1);
    end
    check_val("basic_busy_end", 64'(busy), 64'd0);
    repeat (6) tick();
    check_burst("basic");

    // Gapped slots, one in_valid every third cycle
    do_reset();
    out_ready = 1'b1;
    start_burst();
    for (int s = 0; s < 7; s++) begin
      slot(s, 1'b0);
      repeat (2) tick();
      if (s == 3) check_val("gap_rows_after_s3", 64'(mon_q.size()), 64'd1);
    end
    repeat (6) tick();
    check_burst("gap");

    // Backpressure for the whole burst
    do_reset();
    out_ready = 1'b0;
    burst(0);
    repeat (2) tick();
    check_val("bp_out_valid", 64'(out_valid), 64'd1);
    check_val("bp_overflow", 64'(overflow), 64'd0);
    check_val("bp_head_data", out_data, exp_row(0));
    check_val("bp_head_row", 64'(out_row), 64'd0);
    repeat (3) tick();
    check_val("bp_head_stable", out_data, exp_row(0));
    check_val("bp_no_pops", 64'(mon_q.size()), 64'd0);
    out_ready = 1'b1;
    repeat (6) tick();
    check_burst("bp");

    // Overflow: full FIFO, second burst; slot 4 push coincides with a pop
    do_reset();
    out_ready = 1'b0;
    burst(0);
    start_burst();
    slot(0, 1'b0);
    slot(1, 1'b0);
    slot(2, 1'b0);
    check_val("ovf_before_drop", 64'(overflow), 64'd0);
    slot(3, 1'b0);
    check_val("ovf_after_drop", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    slot(4, 1'b0);
    out_ready = 1'b0;
    slot(5, 1'b0);
    slot(6, 1'b0);
    check_val("ovf_one_pop", 64'(mon_q.size()), 64'd1);
    out_ready = 1'b1;
    repeat (8) tick();
    check_val("ovf_nrows", 64'(mon_q.size()), 64'd5);
    for (int i = 0; i < mon_q.size() && i < 4; i++) begin
      check_val($sformatf("ovf_b1_data%0d", i), mon_q[i].data, exp_row(i));
    end
    if (mon_q.size() == 5) begin
      check_val("ovf_b2_data", mon_q[4].data, exp_row(1));
      check_val("ovf_b2_row", 64'(mon_q[4].row), 64'd1);
      check_val("ovf_b2_last", 64'(mon_q[4].last), 64'd0);
    end
    check_val("ovf_sticky", 64'(overflow), 64'd1);

    // Protocol error: drain_start again at slot 3
    do_reset();
    out_ready = 1'b1;
    start_burst();
    for (int s = 0; s < 7; s++) begin
      slot(s, s == 3);
    end
    repeat (6) tick();
    check_val("perr_flag", 64'(protocol_err), 64'd1);
    check_val("perr_busy", 64'(busy), 64'd0);
    check_val("perr_overflow", 64'(overflow), 64'd0);
    check_burst("perr");

    // Async reset in the middle of EMIT
    do_reset();
    out_ready = 1'b0;
    start_burst();
    for (int s = 0; s < 5; s++) begin
      slot(s, 1'b0);
    end
    check_val("ar_pre_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("ar_out_valid", 64'(out_valid), 64'd0);
    check_val("ar_out_data", out_data, 64'd0);
    check_val("ar_out_row", 64'(out_row), 64'd0);
    check_val("ar_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_q.delete();
    out_ready = 1'b1;
    burst(0);
    repeat (6) tick();
    check_burst("ar");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_deskew_register.md
Name: output_deskew_register

Overview:
- Drain-side counterpart of the per-lane input skew shifters.
- Result lanes leave the systolic array staggered: lane j carries row r at drain sample slot r+j.
- Block delays each lane so that all lanes of a row align, then queues whole rows in a small FIFO.
- Rows are presented to the writeback/output interface with a valid/ready handshake, row index and last flag.

Parameters:
- DATASIZE, 16, bit width of one result element (matches `DATASIZE).
- ARRAYWIDTH, 4, number of array lanes (W); also FIFO depth in rows (matches `ARRAYWIDTH).
- ROWW, $clog2(ARRAYWIDTH) (min 1), width of row index.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- drain_start  input  1  one-cycle pulse: a new drain burst begins; the next in_valid is slot 0.
- in_valid  input  1  one drain sample slot is present on in_data this cycle.
- in_data  input  ARRAYWIDTH*DATASIZE  lane j at [j*DATASIZE +: DATASIZE].
- out_valid  output  1  FIFO head row available.
- out_ready  input  1  consumer accepts head row when out_valid && out_ready.
- out_data  output  ARRAYWIDTH*DATASIZE  aligned row, lane j at same bit position as input.
- out_row  output  ROWW  row index r of head row.
- out_last  output  1  head row is row W-1.
- busy  output  1  state != IDLE.
- overflow  output  1  sticky: an aligned row was dropped because FIFO was full.
- protocol_err  output  1  sticky: drain_start received while busy.

Behaviour:
- Reset (rst_n low, async): state IDLE, slot counter 0, delay lines 0, FIFO empty, all outputs 0.
- Sticky flags clear only on reset.
- FSM states: IDLE, FILL, EMIT.
  - IDLE: drain_start -> FILL with slot counter 0. in_valid is ignored; delay lines are not shifted.
  - FILL: slots 0..W-2. Each in_valid shifts the delay lines and increments the counter. The in_valid at slot W-2 moves to EMIT. If W==1, drain_start goes directly to EMIT.
  - EMIT: slots W-1..2W-2. Each in_valid shifts the delay lines and pushes one aligned row (row = slot-(W-1)). The in_valid at slot 2W-2 pushes row W-1 and returns to IDLE.
- Delay lines: lane j is a shift register of depth W-1-j samples, advancing only on in_valid in FILL/EMIT. Lane W-1 has zero depth (direct). Aligned row lane j = in_data lane j delayed W-1-j slots.
- drain_start while busy: ignored, protocol_err set, burst continues.
- drain_start and in_valid in the same cycle from IDLE: that in_valid is not a slot (ignored).
- Cycles without in_valid hold all state; gaps between slots are arbitrary.
- Push timing: row is written at the edge of its completing in_valid; out_valid may rise the following cycle.
- FIFO: depth W, entry = {row data, row index}. Count width $clog2(W+1).
  - Pop occurs on out_valid && out_ready.
  - Push when full without a same-cycle pop: row dropped, overflow set.
  - Push when full with a same-cycle pop: push accepted, count unchanged.
  - Push when empty: pop is impossible that cycle; no combinational bypass.
- Outputs out_data, out_row and out_last come directly from the FIFO head register/array. They are stable while out_valid && !out_ready.
- out_valid = count != 0.
- Back-to-back bursts are allowed once IDLE; the FIFO may still hold rows from the previous burst.

Decomposition:
- Shared package/defines: DATASIZE, ARRAYWIDTH, lane slice macro, FSM state encoding (IDLE=0, FILL=1, EMIT=2).
- One natural sub-module: deskew_row_fifo, a parameterised W-entry synchronous FIFO with async active-low reset, push/pop/full/empty.

Test Plan:
All scenarios use W=4, DATASIZE=16, and stimulus lane j at slot s = 16'h0R0J with R=s-j (0 when R outside 0..3).
- Basic drain: drain_start, then 7 consecutive in_valid, out_ready=1 -> four rows out in order. Row r lanes 3..0 = 0x0r03,0x0r02,0x0r01,0x0r00. out_row 0..3, out_last only on row 3, busy low after slot 6.
- Gapped slots: in_valid every 3rd cycle (DSP_DELAY=3 pacing) -> identical row contents and order. No row is pushed on non-valid cycles.
- Backpressure: out_ready=0 for the whole burst -> count reaches 4 and overflow stays 0. out_data holds row 0 stable; releasing ready drains rows 0..3.
- Overflow: hold ready low, run two bursts -> first row of the second burst is dropped and overflow=1. A later push is accepted when it coincides with a pop.
- Protocol error: drain_start at slot 3 -> protocol_err=1 and the burst completes normally with correct rows.
- Async reset mid-EMIT: rst_n low between slots 4 and 5 -> outputs 0 immediately, FIFO empty, IDLE. A fresh burst after release yields correct rows.
